// File: rtl/param_parity_counter_pkg.sv
// Shared encodings for the parity-aware counter slice.
//   DIR_UP / DIR_DOWN   : values of the dir input.
//   MODE_WRAP / MODE_SAT: values of the sat_mode input.
package param_parity_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/param_parity_counter_sat_wrap_counter.sv
// Up-only event counter that either wraps from all-ones to zero or
// sticks at all-ones, depending on sat_mode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one event
//   sat_mode   : MODE_WRAP or MODE_SAT
//   q          : registered count
//   full       : q equals all-ones (combinational decode of q)
module sat_wrap_counter
  import param_parity_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat_mode,
  output logic [W-1:0] q,
  output logic         full
);

  localparam logic [W-1:0] ZERO_C     = {W{1'b0}};
  localparam logic [W-1:0] ONE_C      = W'(1);
  localparam logic [W-1:0] ALL_ONES_C = {W{1'b1}};

  logic [W-1:0] q_r;
  logic [W-1:0] q_nxt_s;

  // Next-state selection: clear, then increment with wrap/saturate at all-ones.
  always_comb begin
    q_nxt_s = q_r;
    if (clr) begin
      q_nxt_s = ZERO_C;
    end else if (inc) begin
      if (q_r == ALL_ONES_C) begin
        q_nxt_s = (sat_mode == MODE_WRAP) ? ZERO_C : ALL_ONES_C;
      end else begin
        q_nxt_s = q_r + ONE_C;
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= ZERO_C;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign q    = q_r;
  assign full = (q_r == ALL_ONES_C);

endmodule

// File: rtl/param_parity_counter.sv
// Programmable up/down counter (0..MAX_VAL) with clear, clamped load,
// wrap/saturate mode and a registered boundary flag, plus two event
// counters tallying enabled steps taken from an even / odd count value.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en, clr, load       : step enable, sync clear, sync load (clr > load > en)
//   load_val            : load value, clamped to MAX_VAL
//   dir                 : DIR_UP / DIR_DOWN
//   sat_mode            : MODE_WRAP / MODE_SAT (all three counters)
//   count               : main count
//   even_count/odd_count: steps taken from even / odd count values
//   tc                  : high for the cycle after a boundary step
//   even_full/odd_full  : sub-counter at all-ones
module param_parity_counter
  import param_parity_counter_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int EVEN_W  = 5,
  parameter int ODD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  count,
  output logic [EVEN_W-1:0] even_count,
  output logic [ODD_W-1:0]  odd_count,
  output logic              tc,
  output logic              even_full,
  output logic              odd_full
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             tc_nxt_s;
  logic             step_s;
  logic             even_inc_s;
  logic             odd_inc_s;

  // Main count next state. The boundary is detected by comparing with
  // MAX_VAL / zero before stepping, so non power-of-two moduli work.
  always_comb begin
    count_nxt_s = count_r;
    tc_nxt_s    = 1'b0;
    step_s      = 1'b0;
    if (clr) begin
      count_nxt_s = ZERO_C;
    end else if (load) begin
      count_nxt_s = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      step_s = 1'b1;
      case (dir)
        DIR_UP: begin
          if (count_r == MAX_C) begin
            tc_nxt_s    = 1'b1;
            count_nxt_s = (sat_mode == MODE_SAT) ? MAX_C : ZERO_C;
          end else begin
            count_nxt_s = count_r + ONE_C;
          end
        end
        DIR_DOWN: begin
          if (count_r == ZERO_C) begin
            tc_nxt_s    = 1'b1;
            count_nxt_s = (sat_mode == MODE_SAT) ? ZERO_C : MAX_C;
          end else begin
            count_nxt_s = count_r - ONE_C;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Exactly one sub-counter moves per step, chosen by the pre-step LSB,
  // even when saturation holds the main count.
  assign even_inc_s = step_s & ~count_r[0];
  assign odd_inc_s  = step_s &  count_r[0];

  // Main count and boundary flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO_C;
      tc_r    <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= tc_nxt_s;
    end
  end

  sat_wrap_counter #(.W(EVEN_W)) u_even (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (even_inc_s),
    .sat_mode (sat_mode),
    .q        (even_count),
    .full     (even_full)
  );

  sat_wrap_counter #(.W(ODD_W)) u_odd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (odd_inc_s),
    .sat_mode (sat_mode),
    .q        (odd_count),
    .full     (odd_full)
  );

  assign count = count_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_param_parity_counter.sv
// Directed bench for param_parity_counter: one instance with default
// parameters (dut_a) and one with WIDTH=4, MAX_VAL=9 (dut_b), sharing
// the control inputs. Outputs are sampled 1 time unit after the edge.
module tb_param_parity_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic       dir;
  logic       sat_mode;
  logic [5:0] load_val_a;
  logic [3:0] load_val_b;

  logic [5:0] count_a;
  logic [4:0] even_a;
  logic [3:0] odd_a;
  logic       tc_a, even_full_a, odd_full_a;

  logic [3:0] count_b;
  logic [4:0] even_b;
  logic [3:0] odd_b;
  logic       tc_b, even_full_b, odd_full_b;

  int n_tests;
  int n_fail;
  int tc_hits;

  param_parity_counter dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val_a), .dir(dir), .sat_mode(sat_mode),
    .count(count_a), .even_count(even_a), .odd_count(odd_a), .tc(tc_a),
    .even_full(even_full_a), .odd_full(odd_full_a)
  );

  param_parity_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val_b), .dir(dir), .sat_mode(sat_mode),
    .count(count_b), .even_count(even_b), .odd_count(odd_b), .tc(tc_b),
    .even_full(even_full_b), .odd_full(odd_full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic clear_all();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; tc_hits = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    dir = 1'b1; sat_mode = 1'b0; load_val_a = 6'd0; load_val_b = 4'd0;

    // Reset state
    #12;
    check_val("rst count_a", 32'(count_a), 32'd0);
    check_val("rst even_a", 32'(even_a), 32'd0);
    check_val("rst odd_a", 32'(odd_a), 32'd0);
    check_val("rst tc_a", 32'(tc_a), 32'd0);
    check_val("rst fulls_a", 32'({even_full_a, odd_full_a}), 32'd0);
    check_val("rst count_b", 32'(count_b), 32'd0);
    #1 rst_n = 1'b1;

    // 70 up steps, wrap mode, default modulus
    en = 1'b1; dir = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (tc_a) tc_hits++;
      if (i == 64) check_val("wrap tc at 63->0", 32'(tc_a), 32'd1);
      if (i == 64) check_val("wrap count at 63->0", 32'(count_a), 32'd0);
    end
    en = 1'b0;
    check_val("wrap tc hit count", 32'(tc_hits), 32'd1);
    check_val("wrap count_a", 32'(count_a), 32'd6);
    check_val("wrap even_a", 32'(even_a), 32'd3);
    check_val("wrap odd_a", 32'(odd_a), 32'd3);

    // MAX_VAL=9, down wrap: 2,1,0,9,8
    clear_all();
    sat_mode = 1'b0;
    load_val_b = 4'd2; load = 1'b1;
    tick();
    load = 1'b0;
    check_val("down load count_b", 32'(count_b), 32'd2);
    dir = 1'b0; en = 1'b1;
    tick(); check_val("down s1 count", 32'(count_b), 32'd1); check_val("down s1 tc", 32'(tc_b), 32'd0);
    tick(); check_val("down s2 count", 32'(count_b), 32'd0); check_val("down s2 tc", 32'(tc_b), 32'd0);
    tick(); check_val("down s3 count", 32'(count_b), 32'd9); check_val("down s3 tc", 32'(tc_b), 32'd1);
    tick(); check_val("down s4 count", 32'(count_b), 32'd8); check_val("down s4 tc", 32'(tc_b), 32'd0);
    en = 1'b0;
    check_val("down even_b", 32'(even_b), 32'd2);
    check_val("down odd_b", 32'(odd_b), 32'd2);
    tick();
    check_val("idle tc low", 32'(tc_b), 32'd0);
    check_val("idle count hold", 32'(count_b), 32'd8);

    // Saturate at 9: load 8, 5 up steps
    clear_all();
    sat_mode = 1'b1;
    load_val_b = 4'd8; load = 1'b1;
    tick();
    load = 1'b0; dir = 1'b1; en = 1'b1;
    tick(); check_val("sat s1 count", 32'(count_b), 32'd9); check_val("sat s1 tc", 32'(tc_b), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_val("sat hold count", 32'(count_b), 32'd9);
      check_val("sat hold tc", 32'(tc_b), 32'd1);
    end
    en = 1'b0;
    check_val("sat even_b", 32'(even_b), 32'd1);
    check_val("sat odd_b", 32'(odd_b), 32'd4);

    // Load clamp with en also high: count 3 first, then load 12 -> 9
    load_val_b = 4'd3; load = 1'b1;
    tick();
    check_val("load 3 count_b", 32'(count_b), 32'd3);
    load_val_b = 4'd12; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    check_val("clamp count_b", 32'(count_b), 32'd9);
    check_val("clamp tc_b", 32'(tc_b), 32'd0);
    check_val("clamp even_b", 32'(even_b), 32'd1);
    check_val("clamp odd_b", 32'(odd_b), 32'd4);

    // Sub-counter saturation on default instance: 40 up steps from 0
    clear_all();
    sat_mode = 1'b1; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    en = 1'b0;
    check_val("subsat count_a", 32'(count_a), 32'd40);
    check_val("subsat odd_a", 32'(odd_a), 32'd15);
    check_val("subsat odd_full_a", 32'(odd_full_a), 32'd1);
    check_val("subsat even_a", 32'(even_a), 32'd20);
    check_val("subsat even_full_a", 32'(even_full_a), 32'd0);

    // clr + load + en together
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val_a = 6'd33; load_val_b = 4'd5;
    tick();
    idle_inputs();
    check_val("prio count_a", 32'(count_a), 32'd0);
    check_val("prio odd_a", 32'(odd_a), 32'd0);
    check_val("prio odd_full_a", 32'(odd_full_a), 32'd0);
    check_val("prio count_b", 32'(count_b), 32'd0);
    check_val("prio subs_b", 32'({even_b, odd_b}), 32'd0);

    // Asynchronous reset mid-count at 17
    sat_mode = 1'b0; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check_val("pre-rst count_a", 32'(count_a), 32'd17);
    check_val("pre-rst even_a", 32'(even_a), 32'd9);
    check_val("pre-rst odd_a", 32'(odd_a), 32'd8);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst count_a", 32'(count_a), 32'd0);
    check_val("async rst subs_a", 32'({even_a, odd_a}), 32'd0);
    check_val("async rst tc_a", 32'(tc_a), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check_val("resume count_a", 32'(count_a), 32'd1);
    check_val("resume even_a", 32'(even_a), 32'd1);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_parity_counter.md
Name: param_parity_counter

Overview:
- Parametrised up/down counter with configurable modulus, enable, synchronous clear and parallel load.
- Carries two event sub-counters that tally enabled steps taken from an even and from an odd main-count value.
- Wrap or saturate mode applies to all three counters; a registered terminal-count flag marks each main-count boundary event.
- Sits in datapath/timing logic wherever a programmable, parity-aware cycle or event counter is needed.

Parameters:
- WIDTH, 6, width of main count.
- MAX_VAL, 2**WIDTH-1, terminal value of the main count; the range is 0..MAX_VAL. Legal range is 1 to 2**WIDTH-1.
- EVEN_W, 5, width of even_count.
- ODD_W, 4, width of odd_count.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  step enable.
- clr  in  1  synchronous clear of all counters and flags.
- load  in  1  synchronous parallel load of the main count.
- load_val  in  WIDTH  load value.
- dir  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  0 = wrap, 1 = saturate. Applies to count, even_count and odd_count.
- count  out  WIDTH  main count.
- even_count  out  EVEN_W  number of enabled steps taken while count was even.
- odd_count  out  ODD_W  number of enabled steps taken while count was odd.
- tc  out  1  registered one-cycle boundary flag.
- even_full  out  1  even_count equals all-ones.
- odd_full  out  1  odd_count equals all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, even_count=0, odd_count=0, tc=0, even_full=0, odd_full=0. Reset takes effect at any time, including mid-count.
- Priority per rising edge: clr > load > en > hold.
- clr=1:
  - All counters and tc go to 0 on the next edge.
  - even_full and odd_full follow to 0.
- load=1 (clr=0):
  - count <= min(load_val, MAX_VAL).
  - Sub-counters are unchanged; tc <= 0.
- Step (en=1, clr=0, load=0):
  - Up, count<MAX_VAL: count+1.
  - Up, count==MAX_VAL: wrap mode -> 0; sat mode -> hold at MAX_VAL.
  - Down, count>0: count-1.
  - Down, count==0: wrap mode -> MAX_VAL; sat mode -> hold at 0.
  - tc <= 1 on the edge where the boundary is crossed: up from MAX_VAL or down from 0, in either mode. Otherwise tc <= 0.
  - Parity classification uses the pre-edge count[0]:
    - 0: even_count increments.
    - 1: odd_count increments.
  - Each sub-counter wraps to 0 from all-ones in wrap mode and holds at all-ones in sat mode.
  - Exactly one sub-counter changes per step, including steps where the main count is held by saturation.
- en=0 (no clr, no load):
  - All counters hold; tc <= 0.
- Flags:
  - tc is registered and is never high for two consecutive cycles unless the boundary is crossed again. In sat mode with en held at the boundary, tc stays high each such cycle.
  - even_full and odd_full are combinational decodes of the registered sub-counters.
- Arithmetic:
  - Compare against MAX_VAL before incrementing; no reliance on natural binary overflow unless MAX_VAL = 2**WIDTH-1.
  - The clamp of load_val is an unsigned compare.
- sat_mode and dir may change on any cycle; the new value takes effect on the next edge.
- Latency: all outputs except even_full and odd_full are registered, with one-cycle latency from inputs.

Decomposition:
- Shared package holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - MODE_WRAP=1'b0 and MODE_SAT=1'b1.
- One sub-module, sat_wrap_counter:
  - Parameter W; inputs inc and sat_mode; outputs q and full.
  - Instantiated twice, once for even_count and once for odd_count, with clear through a shared clr input.
- Main count logic stays in the top module.

Test Plan:
- Reset and run, defaults, up, wrap: rst_n pulse, then en=1 for 70 cycles.
  - count goes 0..63, 0..5.
  - tc is high exactly once, on the edge where 63->0.
  - even_count=35 and odd_count=35 wrapped to 3, since 35 mod 16 = 3.
- MAX_VAL=9, down, wrap: load_val=2, load, then 4 down steps.
  - count goes 2,1,0,9,8.
  - tc is high only on the 0->9 edge.
  - even_count=2, odd_count=2.
- Saturate: sat_mode=1, MAX_VAL=9, load 8, then 5 up steps.
  - count goes 9 and holds at 9.
  - tc is high on the 4 held-boundary steps.
  - odd_count increments 4 times and even_count increments once.
- Sub-counter saturation: sat_mode=1, defaults, 40 up steps from 0.
  - odd_count holds at 15 and odd_full=1.
  - even_count=20.
- Priority and clamp:
  - clr, load and en together -> all counters 0.
  - load and en with load_val=12 and MAX_VAL=9 -> count=9 and sub-counters unchanged.
- Mid-operation reset: assert rst_n=0 asynchronously between edges at count=17.
  - Outputs go to 0 immediately, before the next clk edge.
  - Counting resumes from 0 after release.
